// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: operand/counter widths and FSM state encoding for the multiplier
package shift_add_multiplier_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/Adder16bit.sv
// Adder16bit: 16-bit ripple-free behavioural adder with carry in and carry out
module Adder16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Y,
  output logic        Cout
);
  assign {Cout, Y} = 17'(A) + 17'(B) + 17'(Cin);
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 16x16 unsigned shift-and-add multiplier, one add+shift per clock
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 accept;
  logic [WIDTH-1:0]     addend, sum;
  logic                 cout;

  // The low bit of P is the current multiplier bit; it gates the multiplicand into the upper half.
  assign addend = p_q[0] ? mcand_q : '0;

  Adder16bit u_adder (
    .A    (p_q[2*WIDTH-1:WIDTH]),
    .B    (addend),
    .Cin  (1'b0),
    .Y    (sum),
    .Cout (cout)
  );

  // Next-state, datapath and registered-output decode; a start in DONE reloads with no idle gap.
  always_comb begin
    accept  = start && (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    count_d = count_q;
    if (accept) begin
      state_d = LOAD;
      mcand_d = a;
      p_d     = {{WIDTH{1'b0}}, b};
      count_d = '0;
    end else if (state_q == LOAD) begin
      state_d = CALC;
    end else if (state_q == CALC) begin
      p_d     = {cout, sum, p_q[WIDTH-1:1]};
      count_d = count_q + CNT_W'(1);
      state_d = (count_q == CNT_W'(WIDTH - 1)) ? DONE : CALC;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = (state_d == LOAD) || (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any operation and clears every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = p_q;
endmodule
